// File: rtl/waveform_mixer_pkg.sv
// Shared types and width helpers for the waveform mixer and its divider.
// The frame FSM states and the snapshotted combine mode live here.
package waveform_mixer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      ACCUM,
      DIV,
      SAT,
      OUT
   } state_t;

   typedef enum logic {
      MODE_AVG = 1'b0,
      MODE_SUM = 1'b1
   } mode_t;

   // Accumulator width that holds num_ch full-scale samples without overflow.
   function automatic int sum_w(input int sample_w, input int num_ch);
      return sample_w + $clog2(num_ch);
   endfunction

endpackage

// File: rtl/mixer_divider.sv
// Fixed-latency restoring divider: DIV_W quotient bits, one bit per cycle.
// The first step runs on the start cycle, and done pulses once the last bit is in.
module mixer_divider #(
   parameter int DIV_W = 11,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic [DIV_W-1:0] dividend,
   input  logic [CNT_W-1:0] divisor,
   output logic [DIV_W-1:0] quotient,
   output logic             done
);

   localparam int STEP_W = $clog2(DIV_W + 1);

   logic [CNT_W-1:0]  rem_reg;
   logic [DIV_W-1:0]  quo_reg;
   logic [CNT_W-1:0]  dvs_reg;
   logic [STEP_W-1:0] step_reg;
   logic              done_reg;

   logic [CNT_W-1:0]  rem_src;
   logic [DIV_W-1:0]  quo_src;
   logic [CNT_W-1:0]  dvs_src;
   logic [STEP_W-1:0] step_src;
   logic [CNT_W:0]    rem_shift;
   logic              fits;
   logic [CNT_W-1:0]  rem_next;
   logic [DIV_W-1:0]  quo_next;
   logic              active;

   // A start overrides any division in flight and seeds the step from the inputs.
   always_comb begin
      active    = start | (step_reg != '0);
      rem_src   = start ? '0 : rem_reg;
      quo_src   = start ? dividend : quo_reg;
      dvs_src   = start ? divisor : dvs_reg;
      step_src  = start ? STEP_W'(DIV_W) : step_reg;
      rem_shift = {rem_src, quo_src[DIV_W-1]};
      fits      = (rem_shift >= {1'b0, dvs_src});
      // The remainder stays below the divisor, so the low bits carry the full result.
      rem_next  = fits ? (rem_shift[CNT_W-1:0] - dvs_src) : rem_shift[CNT_W-1:0];
      quo_next  = {quo_src[DIV_W-2:0], fits};
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rem_reg  <= '0;
         quo_reg  <= '0;
         dvs_reg  <= '0;
         step_reg <= '0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (active) begin
            rem_reg  <= rem_next;
            quo_reg  <= quo_next;
            dvs_reg  <= dvs_src;
            step_reg <= step_src - STEP_W'(1);
            done_reg <= (step_src == STEP_W'(1));
         end
      end
   end

   assign quotient = quo_reg;
   assign done     = done_reg;

endmodule

// File: rtl/waveform_mixer.sv
// N-channel oscillator mixer: gathers one sample per enabled channel each frame, then emits
// their average or saturating sum. Define WAVEFORM_MIXER_ROUND_EN for round-half-up averaging.
module waveform_mixer
   import waveform_mixer_pkg::*;
#(
   parameter int NUM_CH   = 4,
   parameter int SAMPLE_W = 8
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic [NUM_CH-1:0]          ch_en,
   input  logic                       mode,
   input  logic [NUM_CH-1:0]          done,
   input  logic [NUM_CH*SAMPLE_W-1:0] samples,
   output logic                       ready,
   output logic [SAMPLE_W-1:0]        mix_out,
   output logic                       busy
);

   localparam int SUM_W = sum_w(SAMPLE_W, NUM_CH);
   localparam int DIV_W = SUM_W + 1;
   localparam int CNT_W = $clog2(NUM_CH + 1);
   localparam int IDX_W = $clog2(NUM_CH);
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_CH - 1);
   localparam logic [SAMPLE_W-1:0] MAX_S    = '1;

   state_t              state_reg;
   mode_t               mode_reg;
   logic [NUM_CH-1:0]   pending_reg;
   logic [NUM_CH-1:0]   en_snap_reg;
   logic [NUM_CH-1:0]   done_q_reg;
   logic [SAMPLE_W-1:0] cap_reg [NUM_CH];
   logic [IDX_W-1:0]    idx_reg;
   logic [SUM_W-1:0]    sum_reg;
   logic [CNT_W-1:0]    count_reg;
   logic [SAMPLE_W-1:0] mix_out_reg;
   logic                ready_reg;

   logic [SAMPLE_W-1:0] sample_ch [NUM_CH];
   logic [NUM_CH-1:0]   done_edge;
   logic [NUM_CH-1:0]   cap_hit;
   logic [NUM_CH-1:0]   pending_next;
   logic [SAMPLE_W-1:0] add_val;
   logic [SUM_W-1:0]    sum_next;
   logic [CNT_W-1:0]    count_next;
   logic [DIV_W-1:0]    dividend;
   logic                div_start;
   logic [DIV_W-1:0]    div_quotient;
   logic                div_done;
   logic [SAMPLE_W-1:0] sat_val;
   logic [SAMPLE_W-1:0] div_val;

   assign done_edge = done & ~done_q_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         assign sample_ch[gi] = samples[gi*SAMPLE_W +: SAMPLE_W];
         assign cap_hit[gi]   = done_edge[gi] & pending_reg[gi];
      end
   endgenerate

   assign pending_next = pending_reg & ~cap_hit;

   // The last accumulate step feeds the divider directly so its fixed latency starts on time.
   always_comb begin
      add_val    = en_snap_reg[idx_reg] ? cap_reg[idx_reg] : '0;
      sum_next   = sum_reg + SUM_W'(add_val);
      count_next = count_reg + CNT_W'(en_snap_reg[idx_reg]);
`ifdef WAVEFORM_MIXER_ROUND_EN
      dividend   = DIV_W'(sum_next) + DIV_W'(count_next >> 1);
`else
      dividend   = DIV_W'(sum_next);
`endif
      div_start  = (state_reg == ACCUM) && (idx_reg == LAST_IDX) && (mode_reg == MODE_AVG);
      sat_val    = (sum_reg > SUM_W'(MAX_S)) ? MAX_S : sum_reg[SAMPLE_W-1:0];
      div_val    = (div_quotient > DIV_W'(MAX_S)) ? MAX_S : div_quotient[SAMPLE_W-1:0];
   end

   mixer_divider #(
      .DIV_W (DIV_W),
      .CNT_W (CNT_W)
   ) u_divider (
      .clk      (clk),
      .n_rst    (n_rst),
      .start    (div_start),
      .dividend (dividend),
      .divisor  (count_next),
      .quotient (div_quotient),
      .done     (div_done)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg   <= IDLE;
         mode_reg    <= MODE_AVG;
         pending_reg <= '0;
         en_snap_reg <= '0;
         done_q_reg  <= '0;
         idx_reg     <= '0;
         sum_reg     <= '0;
         count_reg   <= '0;
         mix_out_reg <= '0;
         ready_reg   <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            cap_reg[i] <= '0;
         end
      end else begin
         done_q_reg <= done;
         ready_reg  <= 1'b0;
         case (state_reg)
            IDLE: begin
               // Edges seen here belong to no frame and are dropped.
               if (ch_en != '0) begin
                  pending_reg <= ch_en;
                  en_snap_reg <= ch_en;
                  mode_reg    <= mode_t'(mode);
                  idx_reg     <= '0;
                  sum_reg     <= '0;
                  count_reg   <= '0;
                  state_reg   <= COLLECT;
               end
            end
            COLLECT: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (cap_hit[i]) begin
                     cap_reg[i] <= sample_ch[i];
                  end
               end
               pending_reg <= pending_next;
               if (pending_next == '0) begin
                  state_reg <= ACCUM;
               end
            end
            ACCUM: begin
               sum_reg   <= sum_next;
               count_reg <= count_next;
               if (idx_reg == LAST_IDX) begin
                  idx_reg   <= '0;
                  state_reg <= (mode_reg == MODE_AVG) ? DIV : SAT;
               end else begin
                  idx_reg <= idx_reg + IDX_W'(1);
               end
            end
            DIV: begin
               if (div_done) begin
                  mix_out_reg <= div_val;
                  ready_reg   <= 1'b1;
                  state_reg   <= OUT;
               end
            end
            SAT: begin
               mix_out_reg <= sat_val;
               ready_reg   <= 1'b1;
               state_reg   <= OUT;
            end
            OUT: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign ready   = ready_reg;
   assign mix_out = mix_out_reg;
   assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_waveform_mixer.sv
// Directed bench for waveform_mixer (NUM_CH=4, SAMPLE_W=8) with a result scoreboard.
// Expected values and ready cycles are queued at stimulus time and checked on each ready pulse.
module tb_waveform_mixer;

   localparam int LAT_AVG = 15;
   localparam int LAT_SUM = 5;

   logic        clk;
   logic        n_rst;
   logic [3:0]  ch_en;
   logic        mode;
   logic [3:0]  done;
   logic [31:0] samples;
   logic        ready;
   logic [7:0]  mix_out;
   logic        busy;

   typedef struct {
      logic [7:0] val;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   tests_run;
   int   failed;
   int   cyc;

   waveform_mixer #(
      .NUM_CH   (4),
      .SAMPLE_W (8)
   ) dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .ch_en   (ch_en),
      .mode    (mode),
      .done    (done),
      .samples (samples),
      .ready   (ready),
      .mix_out (mix_out),
      .busy    (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests_run++;
      assert (obs === exp_v) else begin
         failed++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic int avg_model(input int s, input int c);
`ifdef WAVEFORM_MIXER_ROUND_EN
      return (s + c / 2) / c;
`else
      return s / c;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_sample(input int ch, input logic [7:0] v);
      samples[ch*8 +: 8] = v;
   endtask

   // Called just before the tick that carries the frame's final capture edge.
   task automatic push_exp(input int v, input int lat);
      exp_t e;
      e.val = 8'(v);
      e.cyc = cyc + 1 + lat;
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 60) begin
         tick();
         n++;
      end
      if (sb.size() != 0) begin
         check("ready_timeout", 32'(sb.size()), 0);
         sb.delete();
      end
      check("busy_after_frame", busy, 0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (ready) begin
         if (sb.size() == 0) begin
            check("unexpected_ready", ready, 0);
         end else begin
            e = sb.pop_front();
            $display("[TB] ready cycle=%0d mix_out=%0d expect=%0d@%0d", cyc, mix_out, e.val, e.cyc);
            check("mix_out", mix_out, e.val);
            check("ready_cycle", cyc, e.cyc);
            check("busy_in_out", busy, 1);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      tests_run = 0;
      failed    = 0;
      n_rst     = 1'b0;
      ch_en     = '0;
      mode      = 1'b0;
      done      = '0;
      samples   = '0;
      repeat (2) tick();
      check("reset_mix_out", mix_out, 0);
      check("reset_ready", ready, 0);
      check("reset_busy", busy, 0);
      #4 n_rst = 1'b1;
      tick();

      // Average of two channels, captured two cycles apart.
      ch_en = 4'b0011; mode = 1'b0;
      tick();
      check("avg_busy_start", busy, 1);
      ch_en = 4'b0000;
      set_sample(0, 8'd142); done = 4'b0001;
      tick();
      check("avg_busy_collect", busy, 1);
      tick();
      set_sample(1, 8'd203); done = 4'b0011;
      push_exp(avg_model(345, 2), LAT_AVG);
      tick();
      check("avg_busy_accum", busy, 1);
      done = 4'b0000;
      wait_idle();

      // Saturating sum, then a sum that fits.
      ch_en = 4'b0111; mode = 1'b1;
      tick();
      ch_en = 4'b0000;
      set_sample(0, 8'd203); set_sample(1, 8'd243); set_sample(2, 8'd100);
      done = 4'b0111;
      push_exp(255, LAT_SUM);
      tick();
      done = 4'b0000;
      wait_idle();

      ch_en = 4'b0011; mode = 1'b1;
      tick();
      ch_en = 4'b0000;
      set_sample(0, 8'd100); set_sample(1, 8'd50);
      done = 4'b0011;
      push_exp(150, LAT_SUM);
      tick();
      done = 4'b0000;
      wait_idle();

      // All four edges at once, plus a stray ch0 edge during accumulation.
      ch_en = 4'b1111; mode = 1'b0;
      tick();
      ch_en = 4'b0000;
      set_sample(0, 8'd10); set_sample(1, 8'd20); set_sample(2, 8'd30); set_sample(3, 8'd41);
      done = 4'b1111;
      push_exp(avg_model(101, 4), LAT_AVG);
      tick();
      done = 4'b0000;
      tick();
      set_sample(0, 8'd200); done = 4'b0001;
      tick();
      done = 4'b0000;
      wait_idle();

      // ch_en changed mid-frame: this frame still needs ch1, the next uses ch0 only.
      ch_en = 4'b0011; mode = 1'b0;
      tick();
      ch_en = 4'b0001;
      set_sample(0, 8'd60); done = 4'b0001;
      tick();
      tick();
      set_sample(1, 8'd100); done = 4'b0011;
      push_exp(avg_model(160, 2), LAT_AVG);
      tick();
      done = 4'b0000;
      wait_idle();
      tick();
      check("next_frame_busy", busy, 1);
      ch_en = 4'b0000;
      set_sample(0, 8'd77); done = 4'b0001;
      push_exp(77, LAT_AVG);
      tick();
      done = 4'b0000;
      wait_idle();

      // Asynchronous reset while dividing; no ready may follow.
      ch_en = 4'b0001; mode = 1'b0;
      tick();
      ch_en = 4'b0000;
      set_sample(0, 8'd50); done = 4'b0001;
      tick();
      repeat (8) tick();
      check("div_busy", busy, 1);
      #2 n_rst = 1'b0;
      #1;
      check("async_rst_mix_out", mix_out, 0);
      check("async_rst_ready", ready, 0);
      check("async_rst_busy", busy, 0);
      ch_en = 4'b0001;
      #2 n_rst = 1'b1;
      tick();
      check("post_rst_busy", busy, 1);
      ch_en = 4'b0000;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (i % 5 == 4) check("post_rst_waiting", busy, 1);
      end
      done = 4'b0000;
      tick();
      set_sample(0, 8'd99); done = 4'b0001;
      push_exp(99, LAT_AVG);
      tick();
      done = 4'b0000;
      wait_idle();

      // No channels enabled: done toggling must not start a frame.
      ch_en = 4'b0000;
      for (int i = 0; i < 20; i++) begin
         done = done ^ 4'b1111;
         samples = $urandom;
         tick();
         check("idle_busy", busy, 0);
         check("idle_ready", ready, 0);
         check("idle_mix_out", mix_out, 99);
      end
      done = 4'b0000;
      repeat (3) tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
